// File: rtl/arbiter_data_decoder.sv
// Decodes a 26-bit super-pixel word: Gray TOA to binary, LFSR5/LFSR8 codes to step counts.
// Latency: out_valid 2+max(kf,kt) cycles after capture (worst case 256).
// Backpressure: ready only in IDLE; the decoded word is held in OUTPUT until out_ready.
module arbiter_data_decoder #(
    parameter int W_CNT = 16
) (
    input  logic             clk_40MHz,
    input  logic             rst,
    input  logic [25:0]      arbiter_data,
    input  logic             shake_hands_last,
    output logic             shake_hands_next,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [8:0]       toa_bin,
    output logic [4:0]       ftoa_bin,
    output logic [7:0]       tot_bin,
    output logic [3:0]       pix_addr,
    output logic             ftoa_err,
    output logic             tot_err,
    output logic [W_CNT-1:0] word_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    localparam logic [4:0] LFSR5_SEED = 5'b11111;
    localparam logic [7:0] LFSR8_SEED = 8'hFF;
    // Last step index at which each field can still match before it is declared illegal.
    localparam logic [7:0] FTOA_LAST_K = 8'd30;
    localparam logic [7:0] TOT_LAST_K  = 8'd254;

    state_t state_q, state_d;

    logic [4:0]       ftoa_code_q, ftoa_code_d;
    logic [7:0]       tot_code_q,  tot_code_d;
    logic [4:0]       lfsr5_q,     lfsr5_d;
    logic [7:0]       lfsr8_q,     lfsr8_d;
    logic [7:0]       k_q,         k_d;
    logic             f_done_q,    f_done_d;
    logic             t_done_q,    t_done_d;
    logic [8:0]       toa_q,       toa_d;
    logic [4:0]       ftoa_bin_q,  ftoa_bin_d;
    logic [7:0]       tot_bin_q,   tot_bin_d;
    logic [3:0]       pix_q,       pix_d;
    logic             ftoa_err_q,  ftoa_err_d;
    logic             tot_err_q,   tot_err_d;
    logic [W_CNT-1:0] cnt_q,       cnt_d;

    logic capture;
    logic f_hit, f_timeout;
    logic t_hit, t_timeout;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [8:0] gray2bin(input logic [8:0] g);
        logic [8:0] b;
        b[8] = g[8];
        for (int i = 7; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign capture = (state_q == IDLE) && shake_hands_last;

    // Match and timeout detection for the current step index; a done field is frozen.
    assign f_hit     = !f_done_q && (lfsr5_q == ftoa_code_q);
    assign f_timeout = !f_done_q && !f_hit && (k_q == FTOA_LAST_K);
    assign t_hit     = !t_done_q && (lfsr8_q == tot_code_q);
    assign t_timeout = !t_done_q && !t_hit && (k_q == TOT_LAST_K);

    // Next-state and handshake outputs of the control FSM.
    always_comb begin
        state_d          = state_q;
        shake_hands_next = 1'b0;
        out_valid        = 1'b0;
        case (state_q)
            IDLE: begin
                shake_hands_next = 1'b1;
                if (shake_hands_last) begin
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                // Both fields resolved on registered flags, so exit lags resolution by one edge.
                if (f_done_q && t_done_q) begin
                    state_d = OUTPUT;
                end
            end
            OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state: capture, parallel LFSR search, and delivery counting.
    always_comb begin
        ftoa_code_d = ftoa_code_q;
        tot_code_d  = tot_code_q;
        lfsr5_d     = lfsr5_q;
        lfsr8_d     = lfsr8_q;
        k_d         = k_q;
        f_done_d    = f_done_q;
        t_done_d    = t_done_q;
        toa_d       = toa_q;
        ftoa_bin_d  = ftoa_bin_q;
        tot_bin_d   = tot_bin_q;
        pix_d       = pix_q;
        ftoa_err_d  = ftoa_err_q;
        tot_err_d   = tot_err_q;
        cnt_d       = cnt_q;

        if (capture) begin
            toa_d       = gray2bin(arbiter_data[25:17]);
            ftoa_code_d = arbiter_data[16:12];
            tot_code_d  = arbiter_data[11:4];
            pix_d       = arbiter_data[3:0];
            lfsr5_d     = LFSR5_SEED;
            lfsr8_d     = LFSR8_SEED;
            k_d         = 8'd0;
            f_done_d    = 1'b0;
            t_done_d    = 1'b0;
            ftoa_bin_d  = 5'd0;
            tot_bin_d   = 8'd0;
            ftoa_err_d  = 1'b0;
            tot_err_d   = 1'b0;
        end else if (state_q == SEARCH) begin
            // Both LFSRs advance every cycle; k always equals the steps taken from the seed.
            lfsr5_d = {lfsr5_q[3:0], lfsr5_q[4] ^ lfsr5_q[2]};
            lfsr8_d = {lfsr8_q[6:0], lfsr8_q[7] ^ lfsr8_q[5] ^ lfsr8_q[4] ^ lfsr8_q[3]};
            k_d     = k_q + 8'd1;
            if (f_hit) begin
                ftoa_bin_d = k_q[4:0];
                f_done_d   = 1'b1;
            end else if (f_timeout) begin
                ftoa_bin_d = 5'd0;
                ftoa_err_d = 1'b1;
                f_done_d   = 1'b1;
            end
            if (t_hit) begin
                tot_bin_d = k_q;
                t_done_d  = 1'b1;
            end else if (t_timeout) begin
                tot_bin_d = 8'd0;
                tot_err_d = 1'b1;
                t_done_d  = 1'b1;
            end
        end else if ((state_q == OUTPUT) && out_ready) begin
            cnt_d = cnt_q + {{(W_CNT-1){1'b0}}, 1'b1};
        end
    end

    // State and datapath registers with synchronous reset that aborts any word in flight.
    always_ff @(posedge clk_40MHz) begin
        if (rst) begin
            state_q     <= IDLE;
            ftoa_code_q <= '0;
            tot_code_q  <= '0;
            lfsr5_q     <= '0;
            lfsr8_q     <= '0;
            k_q         <= '0;
            f_done_q    <= 1'b0;
            t_done_q    <= 1'b0;
            toa_q       <= '0;
            ftoa_bin_q  <= '0;
            tot_bin_q   <= '0;
            pix_q       <= '0;
            ftoa_err_q  <= 1'b0;
            tot_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ftoa_code_q <= ftoa_code_d;
            tot_code_q  <= tot_code_d;
            lfsr5_q     <= lfsr5_d;
            lfsr8_q     <= lfsr8_d;
            k_q         <= k_d;
            f_done_q    <= f_done_d;
            t_done_q    <= t_done_d;
            toa_q       <= toa_d;
            ftoa_bin_q  <= ftoa_bin_d;
            tot_bin_q   <= tot_bin_d;
            pix_q       <= pix_d;
            ftoa_err_q  <= ftoa_err_d;
            tot_err_q   <= tot_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign toa_bin  = toa_q;
    assign ftoa_bin = ftoa_bin_q;
    assign tot_bin  = tot_bin_q;
    assign pix_addr = pix_q;
    assign ftoa_err = ftoa_err_q;
    assign tot_err  = tot_err_q;
    assign word_cnt = cnt_q;

endmodule

// File: tb/tb_arbiter_data_decoder.sv
// Directed bench for arbiter_data_decoder: hand-computed words plus an LFSR index sweep.
// Latency measured in edges from capture edge T to first out_valid sample.
// Checks hold under backpressure, reset abort and idle out_ready.
module tb_arbiter_data_decoder;

    logic        clk_40MHz;
    logic        rst;
    logic [25:0] arbiter_data;
    logic        shake_hands_last;
    logic        shake_hands_next;
    logic        out_ready;
    logic        out_valid;
    logic [8:0]  toa_bin;
    logic [4:0]  ftoa_bin;
    logic [7:0]  tot_bin;
    logic [3:0]  pix_addr;
    logic        ftoa_err;
    logic        tot_err;
    logic [15:0] word_cnt;

    int n_tests;
    int n_fail;
    int exp_cnt;

    arbiter_data_decoder #(.W_CNT(16)) dut (
        .clk_40MHz        (clk_40MHz),
        .rst              (rst),
        .arbiter_data     (arbiter_data),
        .shake_hands_last (shake_hands_last),
        .shake_hands_next (shake_hands_next),
        .out_ready        (out_ready),
        .out_valid        (out_valid),
        .toa_bin          (toa_bin),
        .ftoa_bin         (ftoa_bin),
        .tot_bin          (tot_bin),
        .pix_addr         (pix_addr),
        .ftoa_err         (ftoa_err),
        .tot_err          (tot_err),
        .word_cnt         (word_cnt)
    );

    initial clk_40MHz = 1'b0;
    always #12.5 clk_40MHz = ~clk_40MHz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] lfsr5_at(input int n);
        logic [4:0] q;
        q = 5'b11111;
        for (int i = 0; i < n; i++) q = {q[3:0], q[4] ^ q[2]};
        return q;
    endfunction

    function automatic logic [7:0] lfsr8_at(input int n);
        logic [7:0] q;
        q = 8'hFF;
        for (int i = 0; i < n; i++) q = {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        return q;
    endfunction

    // Present a word for exactly one edge (edge T); returns #1 after T.
    task automatic start_word(input logic [25:0] data);
        arbiter_data     = data;
        shake_hands_last = 1'b1;
        @(posedge clk_40MHz);
        #1;
        shake_hands_last = 1'b0;
    endtask

    // Count edges after T until out_valid is seen; bounded.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 300) begin
            @(posedge clk_40MHz);
            #1;
            lat++;
        end
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(posedge clk_40MHz);
        #1;
        out_ready = 1'b0;
        exp_cnt++;
    endtask

    task automatic do_word(input string tag, input logic [25:0] data,
                           input logic [8:0] e_toa, input logic [4:0] e_f, input logic [7:0] e_t,
                           input logic e_fe, input logic e_te, input int e_lat);
        int lat;
        check({tag, ".rdy_before"}, shake_hands_next, 1);
        start_word(data);
        check({tag, ".rdy_busy"}, shake_hands_next, 0);
        wait_valid(lat);
        check({tag, ".latency"}, lat, e_lat);
        check({tag, ".toa"}, toa_bin, e_toa);
        check({tag, ".ftoa"}, ftoa_bin, e_f);
        check({tag, ".tot"}, tot_bin, e_t);
        check({tag, ".pix"}, pix_addr, data[3:0]);
        check({tag, ".ftoa_err"}, ftoa_err, e_fe);
        check({tag, ".tot_err"}, tot_err, e_te);
        accept();
        check({tag, ".valid_drop"}, out_valid, 0);
        check({tag, ".cnt"}, word_cnt, exp_cnt);
        check({tag, ".rdy_after"}, shake_hands_next, 1);
    endtask

    initial begin
        int lat;
        logic seen;
        n_tests          = 0;
        n_fail           = 0;
        exp_cnt          = 0;
        rst              = 1'b1;
        arbiter_data     = '0;
        shake_hands_last = 1'b0;
        out_ready        = 1'b0;
        repeat (3) @(posedge clk_40MHz);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst.valid", out_valid, 0);
        check("rst.rdy", shake_hands_next, 1);
        check("rst.fields", {toa_bin, ftoa_bin, tot_bin, pix_addr, ftoa_err, tot_err}, 0);
        check("rst.cnt", word_cnt, 0);

        // out_ready outside OUTPUT has no effect
        out_ready = 1'b1;
        repeat (2) @(posedge clk_40MHz);
        #1;
        out_ready = 1'b0;
        check("idle_ready.cnt", word_cnt, 0);
        check("idle_ready.rdy", shake_hands_next, 1);

        // Reset mid-SEARCH aborts the word
        start_word({9'h100, 5'b11111, 8'h00, 4'h9});
        repeat (20) @(posedge clk_40MHz);
        #1;
        check("abort.pre_valid", out_valid, 0);
        check("abort.pre_toa", toa_bin, 9'h1FF);
        rst = 1'b1;
        @(posedge clk_40MHz);
        #1;
        rst = 1'b0;
        check("abort.rdy", shake_hands_next, 1);
        check("abort.fields", {out_valid, toa_bin, ftoa_bin, tot_bin, pix_addr, ftoa_err, tot_err}, 0);
        check("abort.cnt", word_cnt, 0);
        seen = 1'b0;
        for (int i = 0; i < 270; i++) begin
            @(posedge clk_40MHz);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort.no_valid", seen, 0);
        check("abort.cnt_late", word_cnt, 0);

        // Directed words
        do_word("w1", {9'b000000011, 5'b11110, 8'hFE, 4'h5}, 9'd2, 5'd1, 8'd1, 1'b0, 1'b0, 3);
        do_word("w0", {9'h000, 5'b11111, 8'hFF, 4'h0}, 9'd0, 5'd0, 8'd0, 1'b0, 1'b0, 2);
        do_word("tot_bad", {9'h000, 5'b11111, 8'h00, 4'h3}, 9'd0, 5'd0, 8'd0, 1'b0, 1'b1, 256);
        do_word("ftoa_bad", {9'h100, 5'b00000, 8'hFE, 4'hA}, 9'h1FF, 5'd0, 8'd1, 1'b1, 1'b0, 32);
        do_word("both_bad", {9'h1FF, 5'b00000, 8'h00, 4'hF}, 9'h155, 5'd0, 8'd0, 1'b1, 1'b1, 256);

        // Backpressure: hold out_ready low with a competing word offered
        start_word({9'b000000011, 5'b11110, 8'hFE, 4'h5});
        wait_valid(lat);
        check("hold.latency", lat, 3);
        arbiter_data     = {9'h1FF, 5'b00001, 8'h12, 4'hC};
        shake_hands_last = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_40MHz);
            #1;
            check("hold.valid", out_valid, 1);
            check("hold.rdy", shake_hands_next, 0);
            check("hold.data", {toa_bin, ftoa_bin, tot_bin, pix_addr, ftoa_err, tot_err},
                  {9'd2, 5'd1, 8'd1, 4'h5, 1'b0, 1'b0});
            check("hold.cnt", word_cnt, exp_cnt);
        end
        out_ready = 1'b1;
        @(posedge clk_40MHz);
        #1;
        out_ready        = 1'b0;
        shake_hands_last = 1'b0;
        exp_cnt++;
        check("hold.cnt_after", word_cnt, exp_cnt);
        check("hold.valid_drop", out_valid, 0);
        @(posedge clk_40MHz);
        #1;
        check("hold.no_capture", shake_hands_next, 1);
        check("hold.pix_kept", pix_addr, 4'h5);

        // Sweep every ToT step, cycling FTOA through all 31 steps
        for (int j = 0; j < 255; j++) begin
            do_word("sweep", {9'h000, lfsr5_at(j % 31), lfsr8_at(j), 4'(j)},
                    9'd0, 5'(j % 31), 8'(j), 1'b0, 1'b0, 2 + j);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
